// File: rtl/uart_bus_regfile_if.sv
// Bridge-side bus of uart_bus_regfile: request/grant arbitration plus read/write strobes.
interface uart_bus_regfile_if;
   // Handshake: the master raises int_req and holds it; the slave raises int_gnt once the bus
   // is owned. int_write/int_read are single-cycle strobes accepted only while int_gnt is high.
   // int_rd_data is valid the cycle after an accepted read and held until the next accepted read.
   logic [15:0] int_address;
   logic [7:0]  int_wr_data;
   logic        int_write;
   logic        int_read;
   logic [7:0]  int_rd_data;
   logic        int_req;
   logic        int_gnt;

   modport master (
      output int_address, int_wr_data, int_write, int_read, int_req,
      input  int_rd_data, int_gnt
   );

   modport slave (
      input  int_address, int_wr_data, int_write, int_read, int_req,
      output int_rd_data, int_gnt
   );
endinterface

// File: rtl/uart_bus_regfile.sv
// Register file behind the UART-to-bus bridge: grant FSM, R/W registers, ID register, sticky error.
// Optional access counters at offsets NUM_REGS+1/+2 when UART_REGFILE_ACCESS_CNT_EN is defined.
module uart_bus_regfile #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          NUM_REGS  = 16,
   parameter int          GNT_DELAY = 2,
   parameter logic [7:0]  ID_VALUE  = 8'h5A
) (
   input  logic                  clock,
   input  logic                  reset,
   uart_bus_regfile_if.slave     bus,
   input  logic                  ext_busy,
   output logic [8*NUM_REGS-1:0] reg_out,
   output logic                  err_flag,
   output logic [1:0]            fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_GRANT = 2'd2
   } state_t;

   localparam int         IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [3:0] DLY_LOAD = (GNT_DELAY == 0) ? 4'd0 : 4'(GNT_DELAY - 1);

   state_t                state, state_nx;
   logic [3:0]            dly, dly_nx;
   logic [8*NUM_REGS-1:0] reg_q;
   logic [7:0]            rd_q, rd_mux;
   logic                  err_q;
   logic [15:0]           offset;
   logic [IW-1:0]         idx;
   logic                  gnt, is_rw, is_id, rd_legal;
   logic                  wr_acc, rd_acc, id_clear, err_set;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         dly   <= 4'd0;
      end else begin
         state <= state_nx;
         dly   <= dly_nx;
      end
   end

   always_comb begin
      state_nx = state;
      dly_nx   = dly;
      case (state)
         S_IDLE: begin
            if (bus.int_req && !ext_busy) begin
               if (GNT_DELAY == 0) begin
                  state_nx = S_GRANT;
               end else begin
                  state_nx = S_WAIT;
                  dly_nx   = DLY_LOAD;
               end
            end
         end
         S_WAIT: begin
            // ext_busy freezes the countdown rather than restarting it
            if (!bus.int_req) begin
               state_nx = S_IDLE;
            end else if (!ext_busy) begin
               if (dly == 4'd0) state_nx = S_GRANT;
               else             dly_nx   = dly - 4'd1;
            end
         end
         S_GRANT: begin
            if (!bus.int_req) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign gnt         = (state == S_GRANT);
   assign bus.int_gnt = gnt;
   assign fsm_state   = state;

   assign offset = bus.int_address - BASE_ADDR;
   assign idx    = offset[IW-1:0];
   assign is_rw  = (offset < 16'(NUM_REGS));
   assign is_id  = (offset == 16'(NUM_REGS));

`ifdef UART_REGFILE_ACCESS_CNT_EN
   logic [7:0] wcnt, rcnt;
   logic       is_wcnt, is_rcnt;

   assign is_wcnt  = (offset == 16'(NUM_REGS + 1));
   assign is_rcnt  = (offset == 16'(NUM_REGS + 2));
   assign rd_legal = is_rw || is_id || is_wcnt || is_rcnt;

   // Read-count increments after the read mux captured the old value
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wcnt <= 8'h00;
         rcnt <= 8'h00;
      end else if (id_clear) begin
         wcnt <= 8'h00;
         rcnt <= 8'h00;
      end else begin
         if (wr_acc && is_rw && (wcnt != 8'hFF))   wcnt <= wcnt + 8'd1;
         if (rd_acc && rd_legal && (rcnt != 8'hFF)) rcnt <= rcnt + 8'd1;
      end
   end
`else
   assign rd_legal = is_rw || is_id;
`endif

   assign wr_acc   = bus.int_write && gnt;
   assign rd_acc   = bus.int_read && gnt && !bus.int_write;
   assign id_clear = wr_acc && !bus.int_read && is_id && (bus.int_wr_data == 8'hFF);
   assign err_set  = ((bus.int_write || bus.int_read) && !gnt)
                   || (bus.int_write && bus.int_read)
                   || (wr_acc && !is_rw && !(is_id && (bus.int_wr_data == 8'hFF)))
                   || (rd_acc && !rd_legal);

   always_comb begin
      rd_mux = 8'h00;
      if (is_rw)      rd_mux = reg_q[{idx, 3'b000} +: 8];
      else if (is_id) rd_mux = ID_VALUE;
`ifdef UART_REGFILE_ACCESS_CNT_EN
      else if (is_wcnt) rd_mux = wcnt;
      else if (is_rcnt) rd_mux = rcnt;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         reg_q <= '0;
         rd_q  <= 8'h00;
         err_q <= 1'b0;
      end else begin
         if (wr_acc && is_rw) reg_q[{idx, 3'b000} +: 8] <= bus.int_wr_data;
         if (rd_acc)          rd_q <= rd_mux;
         if (err_set)         err_q <= 1'b1;
         else if (id_clear)   err_q <= 1'b0;
      end
   end

   assign reg_out         = reg_q;
   assign err_flag        = err_q;
   assign bus.int_rd_data = rd_q;

endmodule

// File: tb/tb_uart_bus_regfile.sv
// Directed bench for uart_bus_regfile; BASE_ADDR near the top of the map exercises offset wrap.
// Build with UART_REGFILE_ACCESS_CNT_EN defined to cover the access counters.
module tb_uart_bus_regfile;

   localparam logic [15:0] BASE = 16'hFFF8;
   localparam int          NR   = 16;

   logic          clock;
   logic          reset;
   logic          ext_busy;
   logic [8*NR-1:0] reg_out;
   logic          err_flag;
   logic [1:0]    fsm_state;
   int            chk_cnt;
   int            pass_cnt;
   logic [7:0]    exp_q[$];

   uart_bus_regfile_if bus ();

   uart_bus_regfile #(
      .BASE_ADDR (BASE),
      .NUM_REGS  (NR),
      .GNT_DELAY (2),
      .ID_VALUE  (8'h5A)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .ext_busy  (ext_busy),
      .reg_out   (reg_out),
      .err_flag  (err_flag),
      .fsm_state (fsm_state)
   );

   // Clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Driver tasks: inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
      bus.int_address = addr;
      bus.int_wr_data = data;
      bus.int_write   = 1'b1;
      tick();
      bus.int_write   = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] addr);
      bus.int_address = addr;
      bus.int_read    = 1'b1;
      tick();
      bus.int_read    = 1'b0;
   endtask

   task automatic acquire(output logic ok);
      bus.int_req = 1'b1;
      for (int i = 0; i < 20 && bus.int_gnt !== 1'b1; i++) tick();
      ok = bus.int_gnt;
   endtask

   task automatic release_bus();
      bus.int_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      chk_cnt++;
      if (bus.int_gnt !== 1'b0 || err_flag !== 1'b0 || bus.int_rd_data !== 8'h00 ||
          reg_out !== '0 || fsm_state !== 2'd0)
         $display("FAIL reset_state: gnt=%b err=%b rd=%h reg_out=%h fsm=%0d expected all zero",
                  bus.int_gnt, err_flag, bus.int_rd_data, reg_out, fsm_state);
      else pass_cnt++;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_grant_timing();
      bus.int_req = 1'b1;
      tick();
      tick();
      chk_cnt++;
      if (bus.int_gnt !== 1'b0) $display("FAIL grant_early: got %b expected 0", bus.int_gnt);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.int_gnt !== 1'b1) $display("FAIL grant_latency: got %b expected 1", bus.int_gnt);
      else pass_cnt++;
      bus.int_req = 1'b0;
      tick();
      chk_cnt++;
      if (bus.int_gnt !== 1'b0) $display("FAIL grant_drop: got %b expected 0", bus.int_gnt);
      else pass_cnt++;
      // ext_busy held for 4 edges while waiting
      bus.int_req = 1'b1;
      tick();
      ext_busy = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk_cnt++;
      if (fsm_state !== 2'd1 || bus.int_gnt !== 1'b0)
         $display("FAIL busy_hold: fsm=%0d gnt=%b expected fsm=1 gnt=0", fsm_state, bus.int_gnt);
      else pass_cnt++;
      ext_busy = 1'b0;
      tick();
      chk_cnt++;
      if (bus.int_gnt !== 1'b0) $display("FAIL busy_early: got %b expected 0", bus.int_gnt);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.int_gnt !== 1'b1) $display("FAIL busy_latency: got %b expected 1", bus.int_gnt);
      else pass_cnt++;
      // granted: ext_busy no longer matters
      ext_busy = 1'b1;
      tick();
      chk_cnt++;
      if (bus.int_gnt !== 1'b1) $display("FAIL busy_after_grant: got %b expected 1", bus.int_gnt);
      else pass_cnt++;
      ext_busy = 1'b0;
      release_bus();
   endtask

   task automatic test_write_read();
      logic ok;
      acquire(ok);
      chk_cnt++;
      if (ok !== 1'b1) $display("FAIL wr_grant_timeout: got %b expected 1", ok);
      else pass_cnt++;
      do_write(BASE + 16'd5, 8'h3C);
      chk_cnt++;
      if (reg_out[47:40] !== 8'h3C) $display("FAIL reg5_out: got %h expected 3c", reg_out[47:40]);
      else pass_cnt++;
      do_read(BASE + 16'd5);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h3C) $display("FAIL reg5_read: got %h expected 3c", bus.int_rd_data);
      else pass_cnt++;
      do_read(BASE + 16'd16);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h5A) $display("FAIL id_read: got %h expected 5a", bus.int_rd_data);
      else pass_cnt++;
      do_write(BASE + 16'd15, 8'hE7);
      do_read(BASE + 16'd15);
      chk_cnt++;
      if (bus.int_rd_data !== 8'hE7 || reg_out[127:120] !== 8'hE7 || err_flag !== 1'b0)
         $display("FAIL reg15_rw: rd=%h out=%h err=%b expected e7 e7 0",
                  bus.int_rd_data, reg_out[127:120], err_flag);
      else pass_cnt++;
      // held until next accepted read
      tick();
      tick();
      chk_cnt++;
      if (bus.int_rd_data !== 8'hE7) $display("FAIL rd_hold: got %h expected e7", bus.int_rd_data);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals[4];
      logic [7:0] exp;
      vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3; vals[3] = 8'hD4;
      bus.int_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.int_address = BASE + 16'(8 + i);
         bus.int_wr_data = vals[i];
         exp_q.push_back(vals[i]);
         tick();
      end
      bus.int_write = 1'b0;
      bus.int_read  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.int_address = BASE + 16'(8 + i);
         tick();
         exp = exp_q.pop_front();
         chk_cnt++;
         if (bus.int_rd_data !== exp)
            $display("FAIL b2b_read%0d: got %h expected %h", i, bus.int_rd_data, exp);
         else pass_cnt++;
      end
      bus.int_read = 1'b0;
   endtask

   task automatic test_illegal();
      do_read(BASE + 16'd40);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h00 || err_flag !== 1'b1)
         $display("FAIL oor_read: rd=%h err=%b expected 00 1", bus.int_rd_data, err_flag);
      else pass_cnt++;
      do_write(BASE + 16'd16, 8'h11);
      do_read(BASE + 16'd16);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h5A || err_flag !== 1'b1)
         $display("FAIL id_write_ignored: rd=%h err=%b expected 5a 1", bus.int_rd_data, err_flag);
      else pass_cnt++;
      do_write(BASE + 16'd16, 8'hFF);
      chk_cnt++;
      if (err_flag !== 1'b0) $display("FAIL err_clear: got %b expected 0", err_flag);
      else pass_cnt++;
      // offset 0xFFFF (one below base) is out of range
      do_read(BASE - 16'd1);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h00 || err_flag !== 1'b1)
         $display("FAIL below_base: rd=%h err=%b expected 00 1", bus.int_rd_data, err_flag);
      else pass_cnt++;
      do_read(BASE + 16'd16);
      do_write(BASE + 16'd16, 8'hFF);
   endtask

   task automatic test_ungranted();
      logic ok;
      release_bus();
      do_write(BASE, 8'h77);
      chk_cnt++;
      if (reg_out[7:0] !== 8'h00 || err_flag !== 1'b1)
         $display("FAIL ungranted_write: reg0=%h err=%b expected 00 1", reg_out[7:0], err_flag);
      else pass_cnt++;
      do_read(BASE + 16'd5);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h5A)
         $display("FAIL ungranted_read: got %h expected 5a", bus.int_rd_data);
      else pass_cnt++;
      acquire(ok);
      do_write(BASE + 16'd16, 8'hFF);
      chk_cnt++;
      if (ok !== 1'b1 || err_flag !== 1'b0)
         $display("FAIL regrant_clear: ok=%b err=%b expected 1 0", ok, err_flag);
      else pass_cnt++;
      bus.int_address = BASE + 16'd1;
      bus.int_wr_data = 8'h99;
      bus.int_write   = 1'b1;
      bus.int_read    = 1'b1;
      tick();
      bus.int_write   = 1'b0;
      bus.int_read    = 1'b0;
      chk_cnt++;
      if (reg_out[15:8] !== 8'h99 || err_flag !== 1'b1 || bus.int_rd_data !== 8'h5A)
         $display("FAIL simultaneous: reg1=%h err=%b rd=%h expected 99 1 5a",
                  reg_out[15:8], err_flag, bus.int_rd_data);
      else pass_cnt++;
      do_write(BASE + 16'd16, 8'hFF);
   endtask

   task automatic test_access_cnt();
`ifdef UART_REGFILE_ACCESS_CNT_EN
      do_write(BASE + 16'd16, 8'hFF);
      do_write(BASE + 16'd3, 8'h01);
      do_write(BASE + 16'd4, 8'h02);
      do_write(BASE + 16'd6, 8'h03);
      do_read(BASE + 16'd3);
      do_read(BASE + 16'd4);
      do_read(BASE + 16'd18);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h02) $display("FAIL rd_count: got %h expected 02", bus.int_rd_data);
      else pass_cnt++;
      do_read(BASE + 16'd17);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h03) $display("FAIL wr_count: got %h expected 03", bus.int_rd_data);
      else pass_cnt++;
      for (int i = 0; i < 300; i++) do_write(BASE + 16'd7, 8'(i));
      do_read(BASE + 16'd17);
      chk_cnt++;
      if (bus.int_rd_data !== 8'hFF || err_flag !== 1'b0)
         $display("FAIL wr_count_sat: rd=%h err=%b expected ff 0", bus.int_rd_data, err_flag);
      else pass_cnt++;
      do_write(BASE + 16'd17, 8'h00);
      chk_cnt++;
      if (err_flag !== 1'b1) $display("FAIL cnt_write_err: got %b expected 1", err_flag);
      else pass_cnt++;
      do_write(BASE + 16'd16, 8'hFF);
      do_read(BASE + 16'd17);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h00) $display("FAIL cnt_clear: got %h expected 00", bus.int_rd_data);
      else pass_cnt++;
`else
      do_read(BASE + 16'd17);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h00 || err_flag !== 1'b1)
         $display("FAIL off17_oor: rd=%h err=%b expected 00 1", bus.int_rd_data, err_flag);
      else pass_cnt++;
      do_write(BASE + 16'd16, 8'hFF);
      do_read(BASE + 16'd16);
      do_read(BASE + 16'd18);
      chk_cnt++;
      if (bus.int_rd_data !== 8'h00 || err_flag !== 1'b1)
         $display("FAIL off18_oor: rd=%h err=%b expected 00 1", bus.int_rd_data, err_flag);
      else pass_cnt++;
`endif
   endtask

   task automatic test_reset_mid();
      do_read(BASE + 16'd33);
      do_write(BASE + 16'd2, 8'hA5);
      do_read(BASE + 16'd2);
      chk_cnt++;
      if (bus.int_gnt !== 1'b1 || reg_out[23:16] !== 8'hA5 || bus.int_rd_data !== 8'hA5 ||
          err_flag !== 1'b1)
         $display("FAIL pre_reset: gnt=%b reg2=%h rd=%h err=%b expected 1 a5 a5 1",
                  bus.int_gnt, reg_out[23:16], bus.int_rd_data, err_flag);
      else pass_cnt++;
      #2;
      reset = 1'b0;
      #1;
      chk_cnt++;
      if (bus.int_gnt !== 1'b0 || reg_out !== '0 || bus.int_rd_data !== 8'h00 ||
          err_flag !== 1'b0 || fsm_state !== 2'd0)
         $display("FAIL async_reset: gnt=%b reg_out=%h rd=%h err=%b fsm=%0d expected all zero",
                  bus.int_gnt, reg_out, bus.int_rd_data, err_flag, fsm_state);
      else pass_cnt++;
      bus.int_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      chk_cnt         = 0;
      pass_cnt        = 0;
      ext_busy        = 1'b0;
      bus.int_address = 16'h0000;
      bus.int_wr_data = 8'h00;
      bus.int_write   = 1'b0;
      bus.int_read    = 1'b0;
      bus.int_req     = 1'b0;
      test_reset();
      test_grant_timing();
      test_write_read();
      test_back_to_back();
      test_illegal();
      test_ungranted();
      test_access_cnt();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/uart_bus_regfile.md
Name: uart_bus_regfile

Overview:
- Bus-side register file for the uart2bus_top internal bus: arbitrates `int_req`/`int_gnt`, services `int_write`/`int_read`, and returns `int_rd_data` to the UART parser.
- Holds NUM_REGS 8-bit read/write control registers exported to the design, plus a read-only ID register.
- Sits directly downstream of the UART-to-bus bridge.
- Includes a sticky error flag for illegal accesses.

Parameters:
- BASE_ADDR, 16'h0000, bus address of register offset 0.
- NUM_REGS, 16, number of R/W registers, legal range 1..64.
- GNT_DELAY, 2, cycles from `int_req` rising to `int_gnt` asserted, legal range 0..15.
- ID_VALUE, 8'h5A, constant returned at offset NUM_REGS.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous active-low reset.
- int_address  in  16  bus address from bridge.
- int_wr_data  in  8  write data.
- int_write  in  1  single-cycle write strobe.
- int_read  in  1  single-cycle read strobe.
- int_rd_data  out  8  read data to bridge.
- int_req  in  1  bus request from bridge.
- int_gnt  out  1  bus grant to bridge.
- ext_busy  in  1  another master owns the bus; withholds new grants.
- reg_out  out  8*NUM_REGS  flat export of R/W registers, reg k at bits [8k+7:8k].
- err_flag  out  1  sticky illegal-access indicator.

Behaviour:
- **Reset** (reset=0, async): all registers 8'h00, `int_rd_data`=8'h00, `int_gnt`=0, `err_flag`=0, FSM=IDLE, delay counter=0. The same applies when reset is asserted mid-transaction: grant drops immediately and no partial write is committed.
- **Grant FSM** (states IDLE, WAIT, GRANT):
  - IDLE: `int_gnt`=0. If `int_req`=1 and `ext_busy`=0: with GNT_DELAY=0 go to GRANT; otherwise load counter=GNT_DELAY-1 and go to WAIT.
  - WAIT: if `int_req`=0, go to IDLE. Else if `ext_busy`=1, hold and freeze the counter. Else if counter=0, go to GRANT; otherwise decrement.
  - GRANT: `int_gnt`=1, registered output. `ext_busy` is ignored once granted. When `int_req`=0, go to IDLE and `int_gnt`=0 on the next cycle.
  - Grant latency from the `int_req` sampled high: GNT_DELAY+1 cycles when `ext_busy`=0.
- **Decode:**
  - offset = `int_address` - BASE_ADDR, 16-bit modular.
  - Offsets 0..NUM_REGS-1 are R/W. Offset NUM_REGS is the ID register (read-only). Anything else is out of range.
- **Write** (`int_write`=1 with `int_gnt`=1):
  - R/W offset: register updated at the clock edge; `reg_out` reflects it the following cycle.
  - Write to ID or out-of-range offset: no register change, `err_flag` set.
- **Read** (`int_read`=1 with `int_gnt`=1):
  - `int_rd_data` is registered, valid exactly 1 cycle after the strobe, and held until the next accepted read.
  - R/W offset returns the register, ID offset returns ID_VALUE, out of range returns 8'h00 and sets `err_flag`.
  - Read of a register written in the same cycle is impossible (see simultaneous strobes). A read on the cycle after a write returns the new value.
- **Strobe without grant:** ignored, `err_flag` set, `int_rd_data` unchanged.
- **Simultaneous `int_write` and `int_read`:** write performed, read ignored, `err_flag` set.
- **`err_flag` clearing:** cleared only by reset, or by a write of 8'hFF to the ID offset. That write clears the flag instead of setting it and is the sole legal ID write.
- **Address wrap:** BASE_ADDR near 16'hFFFF is legal; offset arithmetic wraps modulo 2^16.

Optional Feature:
- Macro: UART_REGFILE_ACCESS_CNT_EN.
- Defined:
  - Two extra read-only registers at offsets NUM_REGS+1 (write count) and NUM_REGS+2 (read count).
  - Each is an 8-bit saturating counter at 8'hFF, incremented on each accepted legal write/read.
  - Counter reads themselves are counted after the data is captured.
  - Both counters reset to 0, and both are cleared by the `err_flag`-clear write (8'hFF to ID).
  - Writes to either counter offset are illegal and set `err_flag`.
- Undefined: offsets NUM_REGS+1 and NUM_REGS+2 are out of range (read 8'h00, set `err_flag`).

Test Plan:
- Grant timing: GNT_DELAY=2, `ext_busy`=0, raise `int_req` -> `int_gnt`=1 on the 3rd edge after it is sampled. Drop `int_req` -> `int_gnt`=0 one cycle later. Repeat with `ext_busy`=1 held 4 cycles during WAIT -> grant delayed 4 extra cycles.
- Write/read back: granted, write 8'h3C to BASE_ADDR+5 -> `reg_out[47:40]`=8'h3C next cycle. Read BASE_ADDR+5 -> `int_rd_data`=8'h3C one cycle after the strobe. Read BASE_ADDR+16 -> 8'h5A.
- Illegal accesses: read BASE_ADDR+40 -> `int_rd_data`=8'h00, `err_flag`=1. Write 8'h11 to BASE_ADDR+16 -> ID still reads 8'h5A, flag stays 1. Write 8'hFF to BASE_ADDR+16 -> `err_flag`=0.
- Ungranted strobe: `int_gnt`=0, write 8'h77 to BASE_ADDR+0 -> `reg_out[7:0]` stays 8'h00, `err_flag`=1. Simultaneous write 8'h99 and read at offset 1 -> reg1=8'h99, `err_flag`=1, `int_rd_data` unchanged.
- Reset mid-operation: in GRANT with reg2=8'hA5, pulse reset low mid-cycle -> `int_gnt`, `reg_out`, `int_rd_data`, `err_flag` all 0 immediately, without waiting for a clock edge.
- With UART_REGFILE_ACCESS_CNT_EN: 3 legal writes and 2 legal reads -> offset 17 reads 8'h03, offset 18 reads 8'h02. 300 legal writes -> offset 17 reads 8'hFF.
